// File: rtl/riio_gpo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : riio_gpo_ctrl
// Brief    : Sequencing controller for a general-purpose output pad cell.
//            Applies drive/slew/compensation/open-drain settings only while
//            the output enable is low, waits for IO-ring bias when a non-zero
//            drive strength is requested, lets the pad settle, then enables it.
// Revision : 1.0 - initial release
// ============================================================================
module riio_gpo_ctrl #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned BIAS_TMO    = 255,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic       EN_I,
  input  logic       DATA_I,
  input  logic [1:0] DS_REQ_I,
  input  logic       SR_REQ_I,
  input  logic       CO_REQ_I,
  input  logic [1:0] OD_MODE_I,
  input  logic       VBIAS_OK_I,
  input  logic       ERR_CLR_I,
  output logic       DO_O,
  output logic [1:0] DS_O,
  output logic       SR_O,
  output logic       CO_O,
  output logic       OE_O,
  output logic       ODP_O,
  output logic       ODN_O,
  output logic       READY_O,
  output logic       ERR_O
);

  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC);
  localparam logic [15:0] TMO_LAST  = 16'(BIAS_TMO - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_CFG       = 3'd1,
    S_WAIT_BIAS = 3'd2,
    S_SETTLE    = 3'd3,
    S_ON        = 3'd4,
    S_DRAIN     = 3'd5
  } state_e;

  state_e                   state_q;
  logic [15:0]              cnt_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     vbias_sync;

  // Shadow copy of the configuration currently applied to the pad
  logic [1:0] ds_shadow_q;
  logic       sr_shadow_q;
  logic       co_shadow_q;
  logic [1:0] od_shadow_q;

  // Registered pad controls
  logic       do_q;
  logic [1:0] ds_q;
  logic       sr_q;
  logic       co_q;
  logic       oe_q;
  logic       odp_q;
  logic       odn_q;
  logic       ready_q;
  logic       err_q;

  // Decoded conditions
  logic cfg_diff;
  logic bias_fault_on;
  logic tmo_hit;
  logic err_set;
  logic err_d;

  assign vbias_sync = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous bias-good indication into the clock domain
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], VBIAS_OK_I};
    end
  end

  // Exit/fault conditions and next value of the sticky error flag
  always_comb begin
    cfg_diff      = (DS_REQ_I  != ds_shadow_q) ||
                    (SR_REQ_I  != sr_shadow_q) ||
                    (CO_REQ_I  != co_shadow_q) ||
                    (OD_MODE_I != od_shadow_q);
    bias_fault_on = !vbias_sync && (ds_q != 2'b00);
    tmo_hit       = (cnt_q == TMO_LAST);
    err_set       = ((state_q == S_WAIT_BIAS) && EN_I && !vbias_sync && tmo_hit) ||
                    ((state_q == S_ON) && bias_fault_on);
    // A fault in the same cycle as a clear request keeps the flag set
    err_d         = err_set || (err_q && !ERR_CLR_I);
  end

  // Main sequencer; every pad control is a flop so OE only drops on reset or a clock
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      ds_shadow_q <= '0;
      sr_shadow_q <= 1'b0;
      co_shadow_q <= 1'b0;
      od_shadow_q <= '0;
      do_q        <= 1'b0;
      ds_q        <= '0;
      sr_q        <= 1'b0;
      co_q        <= 1'b0;
      oe_q        <= 1'b0;
      odp_q       <= 1'b0;
      odn_q       <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_OFF: begin
          oe_q    <= 1'b0;
          ready_q <= 1'b0;
          ds_q    <= 2'b00;
          cnt_q   <= '0;
          if (EN_I) begin
            state_q <= S_CFG;
          end
        end

        S_CFG: begin
          if (!EN_I) begin
            state_q <= S_OFF;
            ds_q    <= 2'b00;
            cnt_q   <= '0;
          end else begin
            ds_shadow_q <= DS_REQ_I;
            sr_shadow_q <= SR_REQ_I;
            co_shadow_q <= CO_REQ_I;
            od_shadow_q <= OD_MODE_I;
            ds_q        <= DS_REQ_I;
            sr_q        <= SR_REQ_I;
            co_q        <= CO_REQ_I;
            odp_q       <= (OD_MODE_I == 2'b01);
            odn_q       <= (OD_MODE_I == 2'b10);
            if ((DS_REQ_I != 2'b00) && !vbias_sync) begin
              state_q <= S_WAIT_BIAS;
              cnt_q   <= '0;
            end else begin
              state_q <= S_SETTLE;
              cnt_q   <= SETTLE_LD;
            end
          end
        end

        S_WAIT_BIAS: begin
          if (!EN_I) begin
            state_q <= S_OFF;
            ds_q    <= 2'b00;
            cnt_q   <= '0;
          end else if (vbias_sync) begin
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE_LD;
          end else if (tmo_hit) begin
            // Bias never came: fall back to the weakest drive and flag it
            ds_q    <= 2'b00;
            state_q <= S_SETTLE;
            cnt_q   <= SETTLE_LD;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_SETTLE: begin
          if (!EN_I) begin
            state_q <= S_OFF;
            ds_q    <= 2'b00;
            cnt_q   <= '0;
          end else if (cnt_q == 16'd0) begin
            state_q <= S_ON;
            oe_q    <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end

        S_ON: begin
          do_q <= DATA_I;
          if (!EN_I || cfg_diff || bias_fault_on) begin
            state_q <= S_DRAIN;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
          end
        end

        S_DRAIN: begin
          oe_q    <= 1'b0;
          ready_q <= 1'b0;
          if (EN_I) begin
            state_q <= S_CFG;
          end else begin
            state_q <= S_OFF;
            ds_q    <= 2'b00;
          end
        end

        default: begin
          state_q <= S_OFF;
          oe_q    <= 1'b0;
          ready_q <= 1'b0;
          ds_q    <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign DO_O    = do_q;
  assign DS_O    = ds_q;
  assign SR_O    = sr_q;
  assign CO_O    = co_q;
  assign OE_O    = oe_q;
  assign ODP_O   = odp_q;
  assign ODN_O   = odn_q;
  assign READY_O = ready_q;
  assign ERR_O   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_riio_gpo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_riio_gpo_ctrl
// Brief    : Directed self-checking bench for riio_gpo_ctrl
//            (SETTLE_CYC=4, BIAS_TMO=8, SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riio_gpo_ctrl;

  logic       CLK_I;
  logic       RSTN_I;
  logic       EN_I;
  logic       DATA_I;
  logic [1:0] DS_REQ_I;
  logic       SR_REQ_I;
  logic       CO_REQ_I;
  logic [1:0] OD_MODE_I;
  logic       VBIAS_OK_I;
  logic       ERR_CLR_I;
  logic       DO_O;
  logic [1:0] DS_O;
  logic       SR_O;
  logic       CO_O;
  logic       OE_O;
  logic       ODP_O;
  logic       ODN_O;
  logic       READY_O;
  logic       ERR_O;

  int n_checks = 0;
  int n_fail   = 0;

  riio_gpo_ctrl #(
    .SETTLE_CYC (4),
    .BIAS_TMO   (8),
    .SYNC_STAGES(2)
  ) dut (
    .CLK_I     (CLK_I),
    .RSTN_I    (RSTN_I),
    .EN_I      (EN_I),
    .DATA_I    (DATA_I),
    .DS_REQ_I  (DS_REQ_I),
    .SR_REQ_I  (SR_REQ_I),
    .CO_REQ_I  (CO_REQ_I),
    .OD_MODE_I (OD_MODE_I),
    .VBIAS_OK_I(VBIAS_OK_I),
    .ERR_CLR_I (ERR_CLR_I),
    .DO_O      (DO_O),
    .DS_O      (DS_O),
    .SR_O      (SR_O),
    .CO_O      (CO_O),
    .OE_O      (OE_O),
    .ODP_O     (ODP_O),
    .ODN_O     (ODN_O),
    .READY_O   (READY_O),
    .ERR_O     (ERR_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // All outputs packed for whole-port checks
  function automatic logic [9:0] outs();
    return {DO_O, DS_O, SR_O, CO_O, OE_O, ODP_O, ODN_O, READY_O, ERR_O};
  endfunction

  // Reset holds every output low, also with the clock running
  task automatic test_reset();
    RSTN_I = 1'b0; EN_I = 1'b0; DATA_I = 1'b0; DS_REQ_I = 2'b00;
    SR_REQ_I = 1'b0; CO_REQ_I = 1'b0; OD_MODE_I = 2'b00;
    VBIAS_OK_I = 1'b0; ERR_CLR_I = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 10'b0) begin
      n_fail++; $display("FAIL reset_initial: outs=%b expected %b", outs(), 10'b0);
    end
    repeat (2) @(negedge CLK_I);
    n_checks++;
    if (outs() !== 10'b0) begin
      n_fail++; $display("FAIL reset_clocked: outs=%b expected %b", outs(), 10'b0);
    end
    RSTN_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    n_checks++;
    if (outs() !== 10'b0) begin
      n_fail++; $display("FAIL reset_release_off: outs=%b expected %b", outs(), 10'b0);
    end
  endtask

  // DS=00 skips the bias wait: OE high 6 cycles after EN is sampled
  task automatic test_fast_path();
    EN_I = 1'b1; DS_REQ_I = 2'b00; SR_REQ_I = 1'b1; CO_REQ_I = 1'b1;
    OD_MODE_I = 2'b01; VBIAS_OK_I = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK_I);
      n_checks++;
      if (OE_O !== (k == 7) || READY_O !== (k == 7)) begin
        n_fail++;
        $display("FAIL fast_oe_k%0d: oe=%b ready=%b expected %b", k, OE_O, READY_O, (k == 7));
      end
      if (k == 2) begin
        n_checks++;
        if ({DS_O, SR_O, CO_O, ODP_O, ODN_O} !== 6'b00_1_1_1_0) begin
          n_fail++;
          $display("FAIL fast_cfg_latch: got %b expected %b",
                   {DS_O, SR_O, CO_O, ODP_O, ODN_O}, 6'b001110);
        end
      end
    end
    n_checks++;
    if (ERR_O !== 1'b0) begin
      n_fail++; $display("FAIL fast_err: err=%b expected 0", ERR_O);
    end
  endtask

  // DO follows DATA with one cycle of latency while ON
  task automatic test_data_follow();
    logic [3:0] pat;
    pat = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      DATA_I = pat[i];
      @(negedge CLK_I);
      n_checks++;
      if (DO_O !== pat[i] || OE_O !== 1'b1) begin
        n_fail++;
        $display("FAIL data_follow_%0d: do=%b oe=%b expected do=%b oe=1", 3 - i, DO_O, OE_O, pat[i]);
      end
    end
  endtask

  // Config change while ON: drain, reapply with OE low, settle, re-enable
  task automatic test_cfg_change();
    logic [1:0] exp;
    SR_REQ_I = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      @(negedge CLK_I);
      exp = {(m >= 3) ? 1'b0 : 1'b1, (m == 8) ? 1'b1 : 1'b0};
      n_checks++;
      if ({SR_O, OE_O} !== exp) begin
        n_fail++;
        $display("FAIL cfg_change_m%0d: sr,oe=%b expected %b", m, {SR_O, OE_O}, exp);
      end
    end
  endtask

  // Bias never arrives: DS forced to 00 after 8 wait cycles, error raised
  task automatic test_bias_timeout();
    logic [1:0] exp_ds;
    EN_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    n_checks++;
    if (OE_O !== 1'b0 || DS_O !== 2'b00) begin
      n_fail++; $display("FAIL tmo_off: oe=%b ds=%b expected 0 00", OE_O, DS_O);
    end
    DS_REQ_I = 2'b11; VBIAS_OK_I = 1'b0; EN_I = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK_I);
      exp_ds = (k >= 2 && k <= 9) ? 2'b11 : 2'b00;
      n_checks++;
      if (DS_O !== exp_ds || OE_O !== (k >= 15)) begin
        n_fail++;
        $display("FAIL tmo_k%0d: ds=%b oe=%b expected ds=%b oe=%b", k, DS_O, OE_O, exp_ds, (k >= 15));
      end
      if (k == 9 || k == 10) begin
        n_checks++;
        if (ERR_O !== (k == 10)) begin
          n_fail++; $display("FAIL tmo_err_k%0d: err=%b expected %b", k, ERR_O, (k == 10));
        end
      end
    end
    ERR_CLR_I = 1'b1;
    @(negedge CLK_I);
    ERR_CLR_I = 1'b0;
    n_checks++;
    if (ERR_O !== 1'b0 || OE_O !== 1'b1) begin
      n_fail++; $display("FAIL tmo_err_clear: err=%b oe=%b expected 0 1", ERR_O, OE_O);
    end
  endtask

  // Bias loss in ON with DS=10: OE drops after sync+1 cycles, set beats clear
  task automatic test_bias_loss();
    VBIAS_OK_I = 1'b1; DS_REQ_I = 2'b10;
    @(negedge CLK_I);
    for (int i = 0; i < 20 && OE_O !== 1'b1; i++) @(negedge CLK_I);
    n_checks++;
    if (OE_O !== 1'b1 || DS_O !== 2'b10 || ERR_O !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_reach_on: oe=%b ds=%b err=%b expected 1 10 0", OE_O, DS_O, ERR_O);
    end
    VBIAS_OK_I = 1'b0;
    @(negedge CLK_I);
    n_checks++;
    if (OE_O !== 1'b1) begin
      n_fail++; $display("FAIL loss_n1: oe=%b expected 1", OE_O);
    end
    @(negedge CLK_I);
    n_checks++;
    if (OE_O !== 1'b1) begin
      n_fail++; $display("FAIL loss_n2: oe=%b expected 1", OE_O);
    end
    ERR_CLR_I = 1'b1;
    @(negedge CLK_I);
    ERR_CLR_I = 1'b0; EN_I = 1'b0;
    n_checks++;
    if ({OE_O, READY_O, ERR_O} !== 3'b001) begin
      n_fail++;
      $display("FAIL loss_n3: oe,ready,err=%b expected 001", {OE_O, READY_O, ERR_O});
    end
    @(negedge CLK_I);
    n_checks++;
    if (DS_O !== 2'b00 || ERR_O !== 1'b1) begin
      n_fail++; $display("FAIL loss_off: ds=%b err=%b expected 00 1", DS_O, ERR_O);
    end
    ERR_CLR_I = 1'b1;
    @(negedge CLK_I);
    ERR_CLR_I = 1'b0;
    n_checks++;
    if (ERR_O !== 1'b0) begin
      n_fail++; $display("FAIL loss_err_clear: err=%b expected 0", ERR_O);
    end
  endtask

  // Reset between clock edges mid-SETTLE and mid-ON clears outputs at once
  task automatic test_async_reset();
    DS_REQ_I = 2'b00; SR_REQ_I = 1'b1; OD_MODE_I = 2'b01; VBIAS_OK_I = 1'b0; EN_I = 1'b1;
    repeat (4) @(negedge CLK_I);
    n_checks++;
    if (SR_O !== 1'b1 || ODP_O !== 1'b1 || OE_O !== 1'b0) begin
      n_fail++; $display("FAIL ares_settle_pre: sr=%b odp=%b oe=%b expected 1 1 0", SR_O, ODP_O, OE_O);
    end
    #2 RSTN_I = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 10'b0) begin
      n_fail++; $display("FAIL ares_settle: outs=%b expected %b", outs(), 10'b0);
    end
    @(negedge CLK_I);
    RSTN_I = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK_I);
      if (k >= 6) begin
        n_checks++;
        if (OE_O !== (k == 7)) begin
          n_fail++; $display("FAIL ares_restart_k%0d: oe=%b expected %b", k, OE_O, (k == 7));
        end
      end
    end
    DATA_I = 1'b1;
    @(negedge CLK_I);
    n_checks++;
    if (DO_O !== 1'b1 || OE_O !== 1'b1) begin
      n_fail++; $display("FAIL ares_on_pre: do=%b oe=%b expected 1 1", DO_O, OE_O);
    end
    #2 RSTN_I = 1'b0;
    #1;
    n_checks++;
    if (outs() !== 10'b0) begin
      n_fail++; $display("FAIL ares_on: outs=%b expected %b", outs(), 10'b0);
    end
    EN_I = 1'b0;
    @(negedge CLK_I);
    RSTN_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    n_checks++;
    if (outs() !== 10'b0) begin
      n_fail++; $display("FAIL ares_off_after: outs=%b expected %b", outs(), 10'b0);
    end
  endtask

  initial begin
    test_reset();
    test_fast_path();
    test_data_follow();
    test_cfg_change();
    test_bias_timeout();
    test_bias_loss();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/riio_gpo_ctrl.md
RIIO_GPO_CTRL -- requirements
Module: riio_gpo_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 4, cycles OE_O is held low after a config is applied, before it may rise; legal range 1..255.
REQ-002 Parameter BIAS_TMO, default 255, cycles to wait for synchronized VBIAS_OK_I before falling back to DS 2'b00; legal range 1..65535.
REQ-003 Parameter SYNC_STAGES, default 2, flop depth of the VBIAS_OK_I synchronizer; legal range 2..4.
REQ-004 CLK_I  input  1  single block clock; all state changes on its rising edge.
REQ-005 RSTN_I  input  1  reset; asynchronous assertion, active-low.
REQ-006 EN_I  input  1  level request to drive the pad.
REQ-007 DATA_I  input  1  output data.
REQ-008 DS_REQ_I  input  2  requested drive strength.
REQ-009 SR_REQ_I / CO_REQ_I  input  1 each  requested slew-rate / compensation setting.
REQ-010 OD_MODE_I  input  2  00 push-pull, 01 open-drain (pull-down only), 10 open-source (pull-up only), 11 treated as 00.
REQ-011 VBIAS_OK_I  input  1  asynchronous bias-good indication from the IO ring.
REQ-012 ERR_CLR_I  input  1  single-cycle pulse clearing ERR_O.
REQ-013 DO_O, DS_O[1:0], SR_O, CO_O, OE_O, ODP_O, ODN_O  output  1/2/1/1/1/1/1  registered pad-cell controls (DO_I, DS_I, SR_I, CO_I, OE_I, ODP_I, ODN_I of the GPO cell).
REQ-014 READY_O  output  1  high exactly when state is ON.
REQ-015 ERR_O  output  1  sticky bias fault flag.

Function
REQ-016 FSM states: OFF, CFG, WAIT_BIAS, SETTLE, ON, DRAIN; all outputs driven from flops, no combinational input-to-output path.
REQ-017 OFF: OE_O=0, DS_O=00; EN_I=1 -> CFG next cycle.
REQ-018 CFG (1 cycle): latch DS_REQ_I, SR_REQ_I, CO_REQ_I, OD_MODE_I into shadow and onto DS_O/SR_O/CO_O/ODP_O/ODN_O; OE_O stays 0; next WAIT_BIAS if latched DS != 00 and vbias_sync=0, else SETTLE.
REQ-019 ODP_O = (mode==01), ODN_O = (mode==10), updated only in CFG.
REQ-020 WAIT_BIAS: 16-bit counter increments each cycle; vbias_sync=1 -> SETTLE; counter reaching BIAS_TMO -> DS_O forced to 00, ERR_O set, -> SETTLE.
REQ-021 SETTLE: counter loaded with SETTLE_CYC, decrements per cycle; at count 0 -> ON; OE_O rises first cycle of ON.
REQ-022 ON: OE_O=1, READY_O=1, DO_O <= DATA_I every cycle (1-cycle latency DATA_I -> DO_O).
REQ-023 ON exit to DRAIN when any of: EN_I=0; DS_REQ_I/SR_REQ_I/CO_REQ_I/OD_MODE_I differ from shadow; vbias_sync=0 while DS_O != 00 (also sets ERR_O).
REQ-024 DRAIN (1 cycle): OE_O=0, DO_O holds; next CFG if EN_I=1, else OFF (DS_O<=00 on entry to OFF).
REQ-025 DS_O, SR_O, CO_O, ODP_O, ODN_O SHALL never change in a cycle where OE_O=1.
REQ-026 EN_I dropping in CFG, WAIT_BIAS or SETTLE -> OFF next cycle, counters cleared.
REQ-027 ERR_O sets on fault, clears on ERR_CLR_I; simultaneous set and clear -> set wins.
REQ-028 vbias_sync is VBIAS_OK_I through SYNC_STAGES flops reset to 0.

Reset
REQ-029 RSTN_I low: state OFF, all outputs 0, counters, shadow and synchronizer 0, asynchronously; release takes effect at next CLK_I edge.
REQ-030 Reset asserted in ON SHALL drop OE_O to 0 immediately without waiting for a clock.

Verification
REQ-031 VBIAS_OK_I=0, DS_REQ_I=00, EN_I 0->1 -> OE_O=1 exactly 1+1+SETTLE_CYC (6) cycles after EN_I sampled, ERR_O=0.
REQ-032 DS_REQ_I=11, VBIAS_OK_I=0 held, BIAS_TMO=8 -> DS_O 11 then 00 after 8 WAIT_BIAS cycles, ERR_O=1, OE_O rises after SETTLE.
REQ-033 In ON, toggle DATA_I 0,1,1,0 -> DO_O follows one cycle later; OE_O stays 1.
REQ-034 In ON, change SR_REQ_I -> OE_O low next cycle, SR_O updates only while OE_O=0, OE_O back high after SETTLE_CYC.
REQ-035 In ON with DS_O=10, VBIAS_OK_I falls -> after SYNC_STAGES+1 cycles OE_O=0, ERR_O=1; ERR_CLR_I pulse clears it.
REQ-036 RSTN_I asserted mid-SETTLE and mid-ON -> all outputs 0 asynchronously, FSM in OFF after release.
